// File: rtl/score_recorder.sv
// score_recorder: 4x4 best-score table with a per-user running average.
// In: clk, rst_n, finished, score, user, song_num, clear_user. Out: rec_score, user_avg, avg_valid, new_best, busy.
module score_recorder #(
  parameter int SCORE_W = 41
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               finished,
  input  logic [SCORE_W-1:0] score,
  input  logic [1:0]         user,
  input  logic [1:0]         song_num,
  input  logic               clear_user,
  output logic [SCORE_W-1:0] rec_score,
  output logic [SCORE_W-1:0] user_avg,
  output logic               avg_valid,
  output logic               new_best,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITE,
    CLEAR,
    SUM,
    DONE
  } state_t;

  state_t             state;
  logic [SCORE_W-1:0] rec [16];

  logic               fin_q;
  logic               clr_q;
  logic [1:0]         user_q;

  logic [1:0]         cap_user;
  logic [1:0]         cap_song;
  logic [SCORE_W-1:0] cap_score;

  logic               pend_fin;
  logic               pend_clr;
  logic [1:0]         pend_user;
  logic [1:0]         pend_song;
  logic [SCORE_W-1:0] pend_score;

  logic [1:0]         sum_k;
  logic [SCORE_W+1:0] acc;

  logic               fin_edge;
  logic               clr_edge;
  logic               user_chg;
  logic [3:0]         cap_idx;
  logic [3:0]         sum_idx;
  logic               better;

  assign fin_edge = finished & ~fin_q;
  assign clr_edge = clear_user & ~clr_q;
  assign user_chg = user != user_q;
  assign cap_idx  = {cap_user, cap_song};
  assign sum_idx  = {cap_user, sum_k};
  assign better   = cap_score > rec[cap_idx];

  // A queued request keeps busy high across the single IDLE
  // cycle between two back-to-back operations.
  assign busy = (state != IDLE) | pend_fin | pend_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 16; i++) begin
        rec[i] <= '0;
      end
      fin_q      <= 1'b0;
      clr_q      <= 1'b0;
      // Track the live selection so leaving reset is not a user change.
      user_q     <= user;
      cap_user   <= '0;
      cap_song   <= '0;
      cap_score  <= '0;
      pend_fin   <= 1'b0;
      pend_clr   <= 1'b0;
      pend_user  <= '0;
      pend_song  <= '0;
      pend_score <= '0;
      sum_k      <= '0;
      acc        <= '0;
      rec_score  <= '0;
      user_avg   <= '0;
      avg_valid  <= 1'b1;
      new_best   <= 1'b0;
    end else begin
      fin_q     <= finished;
      clr_q     <= clear_user;
      new_best  <= 1'b0;
      rec_score <= rec[{user, song_num}];

      // Requests arriving mid-operation are queued one deep;
      // the finished payload is frozen at the edge.
      if (state != IDLE) begin
        if (fin_edge && !pend_fin) begin
          pend_fin   <= 1'b1;
          pend_user  <= user;
          pend_song  <= song_num;
          pend_score <= score;
        end
        if (clr_edge) begin
          pend_clr <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (pend_fin || fin_edge) begin
            state     <= CAPTURE;
            avg_valid <= 1'b0;
            if (pend_fin) begin
              cap_user  <= pend_user;
              cap_song  <= pend_song;
              cap_score <= pend_score;
              user_q    <= pend_user;
            end else begin
              cap_user  <= user;
              cap_song  <= song_num;
              cap_score <= score;
              user_q    <= user;
            end
            // Serving the queued one while a fresh edge lands:
            // the fresh one takes the queue slot.
            pend_fin <= pend_fin & fin_edge;
            if (pend_fin && fin_edge) begin
              pend_user  <= user;
              pend_song  <= song_num;
              pend_score <= score;
            end
            if (clr_edge) begin
              pend_clr <= 1'b1;
            end
          end else if (pend_clr || clr_edge) begin
            state     <= CLEAR;
            avg_valid <= 1'b0;
            cap_user  <= user;
            user_q    <= user;
            pend_clr  <= pend_clr & clr_edge;
          end else if (user_chg) begin
            state     <= SUM;
            avg_valid <= 1'b0;
            cap_user  <= user;
            user_q    <= user;
            acc       <= '0;
            sum_k     <= '0;
          end
        end

        CAPTURE: begin
          state <= WRITE;
        end

        WRITE: begin
          if (better) begin
            rec[cap_idx] <= cap_score;
            new_best     <= 1'b1;
          end
          acc   <= '0;
          sum_k <= '0;
          state <= SUM;
        end

        CLEAR: begin
          for (int k = 0; k < 4; k++) begin
            rec[{cap_user, 2'(k)}] <= '0;
          end
          acc   <= '0;
          sum_k <= '0;
          state <= SUM;
        end

        SUM: begin
          acc   <= acc + {2'b00, rec[sum_idx]};
          sum_k <= sum_k + 2'd1;
          if (sum_k == 2'd3) begin
            state <= DONE;
          end
        end

        DONE: begin
          user_avg  <= acc[SCORE_W+1:2];
          // A user switched during the sum leaves the result stale;
          // IDLE then sees the change and recomputes.
          avg_valid <= cap_user == user;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_recorder.sv
// tb_score_recorder: directed stimulus for score_recorder.
// A scheduling model predicts every output each cycle; literals pin key points.
module tb_score_recorder;

  localparam int W = 41;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         finished = 1'b0;
  logic         clear_user = 1'b0;
  logic [W-1:0] score = '0;
  logic [1:0]   user = 2'd1;
  logic [1:0]   song_num = 2'd2;
  logic [W-1:0] rec_score;
  logic [W-1:0] user_avg;
  logic         avg_valid;
  logic         new_best;
  logic         busy;

  int checks = 0;
  int errors = 0;

  score_recorder #(.SCORE_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .finished   (finished),
    .score      (score),
    .user       (user),
    .song_num   (song_num),
    .clear_user (clear_user),
    .rec_score  (rec_score),
    .user_avg   (user_avg),
    .avg_valid  (avg_valid),
    .new_best   (new_best),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Records table plus one in-flight operation described by kind,
  // start edge and length; effects land at fixed offsets from start.
  logic [W-1:0] m_rec [16];
  logic [W-1:0] x_rec;
  logic [W-1:0] x_avg;
  logic         x_valid;
  logic         x_nb;
  logic         x_busy;
  int           ecount;
  int           free_at;
  int           op_kind;
  int           op_s;
  int           op_len;
  logic [1:0]   op_user;
  logic [1:0]   op_song;
  logic [W-1:0] op_score;
  logic         pf;
  logic         pc;
  logic [1:0]   pf_user;
  logic [1:0]   pf_song;
  logic [W-1:0] pf_score;
  logic         m_fin;
  logic         m_clr;
  logic [1:0]   m_last_user;
  logic         fe;
  logic         ce;
  logic         took_pf;

  function automatic logic [W-1:0] mean_of(input logic [1:0] u);
    logic [W+1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s = s + {2'b00, m_rec[{u, 2'(k)}]};
    end
    s = s / 4;
    return s[W-1:0];
  endfunction

  // kind 1 = finished (8 edges), 2 = clear (7), 3 = recompute (6)
  task automatic start(input int kind, input logic [1:0] u,
                       input logic [1:0] s, input logic [W-1:0] sc);
    op_kind     = kind;
    op_s        = ecount;
    op_len      = (kind == 1) ? 8 : (kind == 2) ? 7 : 6;
    op_user     = u;
    op_song     = s;
    op_score    = sc;
    free_at     = ecount + op_len;
    x_valid     = 1'b0;
    m_last_user = u;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_rec[i] = '0;
      end
      x_rec       = '0;
      x_avg       = '0;
      x_valid     = 1'b1;
      x_nb        = 1'b0;
      x_busy      = 1'b0;
      ecount      = 0;
      free_at     = 0;
      op_kind     = 0;
      pf          = 1'b0;
      pc          = 1'b0;
      m_fin       = 1'b0;
      m_clr       = 1'b0;
      m_last_user = user;
    end else begin
      x_rec = m_rec[{user, song_num}];
      x_nb  = 1'b0;
      if (op_kind == 2 && ecount == op_s + 1) begin
        for (int k = 0; k < 4; k++) begin
          m_rec[{op_user, 2'(k)}] = '0;
        end
      end
      if (op_kind == 1 && ecount == op_s + 2) begin
        if (op_score > m_rec[{op_user, op_song}]) begin
          m_rec[{op_user, op_song}] = op_score;
          x_nb = 1'b1;
        end
      end
      if (op_kind != 0 && ecount == op_s + op_len - 1) begin
        x_avg   = mean_of(op_user);
        x_valid = op_user == user;
        op_kind = 0;
      end
      fe = finished && !m_fin;
      ce = clear_user && !m_clr;
      if (ecount >= free_at) begin
        if (pf || fe) begin
          took_pf = pf;
          if (pf) start(1, pf_user, pf_song, pf_score);
          else start(1, user, song_num, score);
          if (took_pf && fe) begin
            pf_user  = user;
            pf_song  = song_num;
            pf_score = score;
          end else begin
            pf = 1'b0;
          end
          if (ce) pc = 1'b1;
        end else if (pc || ce) begin
          start(2, user, 2'd0, '0);
          pc = pc && ce;
        end else if (user != m_last_user) begin
          start(3, user, 2'd0, '0);
        end
      end else begin
        if (fe && !pf) begin
          pf       = 1'b1;
          pf_user  = user;
          pf_song  = song_num;
          pf_score = score;
        end
        if (ce) pc = 1'b1;
      end
      m_fin  = finished;
      m_clr  = clear_user;
      x_busy = (ecount < free_at - 1) || pf || pc;
      ecount++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chkv("rec_score", rec_score, x_rec);
      chkv("user_avg", user_avg, x_avg);
      chkb("avg_valid", avg_valid, x_valid);
      chkb("new_best", new_best, x_nb);
      chkb("busy", busy, x_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) begin
      tick(1);
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: got busy=1 want busy=0");
    end
  endtask

  task automatic fin_pulse(input logic [1:0] s, input logic [W-1:0] sc);
    song_num = s;
    score    = sc;
    finished = 1'b1;
    tick(1);
    finished = 1'b0;
    wait_idle();
  endtask

  logic [W-1:0] maxv;

  initial begin
    maxv = '1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_valid", avg_valid, 1'b1);
    chkv("rst_avg", user_avg, 0);
    chkv("rst_rec", rec_score, 0);

    // basic capture, latency pinned edge by edge
    score    = 400;
    finished = 1'b1;
    tick(1);
    chkb("cap_busy_e0", busy, 1'b1);
    finished = 1'b0;
    tick(2);
    chkb("cap_nb_e2", new_best, 1'b1);
    tick(1);
    chkv("cap_rec_e3", rec_score, 400);
    tick(3);
    chkb("cap_busy_e6", busy, 1'b1);
    tick(1);
    chkv("cap_avg_e7", user_avg, 100);
    chkb("cap_valid_e7", avg_valid, 1'b1);
    chkb("cap_busy_e7", busy, 1'b0);

    // lower then equal score: no write
    fin_pulse(2'd2, 300);
    chkv("lower_avg", user_avg, 100);
    fin_pulse(2'd2, 400);
    chkv("equal_avg", user_avg, 100);
    chkv("equal_rec", rec_score, 400);

    // truncation
    clear_user = 1'b1;
    tick(1);
    clear_user = 1'b0;
    wait_idle();
    chkv("clear_avg", user_avg, 0);
    for (int s = 0; s < 3; s++) fin_pulse(2'(s), 1);
    chkv("trunc_avg0", user_avg, 0);
    for (int s = 0; s < 3; s++) fin_pulse(2'(s), 3);
    fin_pulse(2'd3, 4);
    chkv("trunc_avg3", user_avg, 3);

    // clear arrives two cycles into a capture
    song_num = 2'd3;
    score    = 50;
    finished = 1'b1;
    tick(1);
    chkb("pend_busy_e0", busy, 1'b1);
    finished = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 2) clear_user = 1'b1;
      if (e == 3) clear_user = 1'b0;
      tick(1);
      if (e < 14) chkb("pend_busy", busy, 1'b1);
      if (e == 7) chkv("pend_avg_mid", user_avg, 14);
    end
    chkb("pend_busy_end", busy, 1'b0);
    chkv("pend_avg_end", user_avg, 0);
    chkb("pend_valid_end", avg_valid, 1'b1);

    // user switch during the sum
    user = 2'd2;
    fin_pulse(2'd1, 80);
    chkv("u2_avg", user_avg, 20);
    user = 2'd1;
    tick(1);
    wait_idle();
    chkv("u1_avg", user_avg, 0);
    song_num = 2'd0;
    score    = 8;
    finished = 1'b1;
    tick(1);
    finished = 1'b0;
    tick(4);
    user = 2'd2;
    tick(3);
    chkb("sw_valid_e7", avg_valid, 1'b0);
    chkv("sw_avg_e7", user_avg, 2);
    tick(6);
    chkb("sw_valid_e13", avg_valid, 1'b1);
    chkv("sw_avg_e13", user_avg, 20);

    // widest scores
    user = 2'd3;
    tick(1);
    wait_idle();
    for (int s = 0; s < 4; s++) fin_pulse(2'(s), maxv);
    chkv("max_avg", user_avg, maxv);
    chkv("max_rec", rec_score, maxv);

    // finished and clear together: finished first, then clear
    song_num   = 2'd0;
    score      = 5;
    finished   = 1'b1;
    clear_user = 1'b1;
    tick(1);
    finished   = 1'b0;
    clear_user = 1'b0;
    wait_idle();
    chkv("both_avg", user_avg, 0);

    // second queued finished is dropped; payload sampled at edge
    user = 2'd0;
    tick(1);
    wait_idle();
    song_num = 2'd0;
    score    = 10;
    finished = 1'b1;
    tick(1);
    finished = 1'b0;
    tick(1);
    song_num = 2'd1;
    score    = 20;
    finished = 1'b1;
    tick(1);
    finished = 1'b0;
    tick(1);
    song_num = 2'd2;
    score    = 30;
    finished = 1'b1;
    tick(1);
    finished = 1'b0;
    wait_idle();
    chkv("drop_avg", user_avg, 7);
    song_num = 2'd1;
    tick(2);
    chkv("drop_rec1", rec_score, 20);
    song_num = 2'd2;
    tick(2);
    chkv("drop_rec2", rec_score, 0);

    // reset before the write edge
    user     = 2'd1;
    tick(1);
    wait_idle();
    song_num = 2'd1;
    score    = 99;
    finished = 1'b1;
    tick(1);
    finished = 1'b0;
    rst_n    = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chkb("rstw_busy", busy, 1'b0);
    chkb("rstw_valid", avg_valid, 1'b1);
    chkv("rstw_avg", user_avg, 0);
    chkv("rstw_rec", rec_score, 0);
    chkb("rstw_nb", new_best, 1'b0);
    tick(4);
    chkv("rstw_rec_late", rec_score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_recorder.md
SCORE_RECORDER -- requirements
Module: score_recorder

Interface
REQ-001 Parameter SCORE_W, default 41, SHALL set the width of every score, record and average value.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 finished  input  1  learning-mode completion level; a 0->1 transition marks a finished song.
REQ-005 score  input  SCORE_W  score of the finished song, valid while finished=1.
REQ-006 user  input  2  selected user, 0..3.
REQ-007 song_num  input  2  selected song, 0..3.
REQ-008 clear_user  input  1  level; a 0->1 transition requests zeroing of the current user's four records.
REQ-009 rec_score  output  SCORE_W  stored record for {user, song_num}, registered.
REQ-010 user_avg  output  SCORE_W  mean of the current user's four records.
REQ-011 avg_valid  output  1  user_avg is current for the user shown.
REQ-012 new_best  output  1  one-cycle pulse when a record is raised.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Storage SHALL be 16 records of SCORE_W bits, indexed {user, song_num}.
REQ-015 Edge detection SHALL use registered copies fin_q, clr_q and user_q.
- A finished edge is finished & ~fin_q.
- A clear edge is clear_user & ~clr_q.
- A user change is user != user_q.
REQ-016 FSM states SHALL be IDLE, CAPTURE, WRITE, CLEAR, SUM, DONE.
REQ-017 IDLE priority SHALL be: pending-or-new finished edge, then pending-or-new clear edge, then user change, then stay.
REQ-018 On a finished edge, the FSM SHALL go to CAPTURE and latch user, song_num and score into cap_user, cap_song and cap_score.
REQ-019 CAPTURE SHALL go to WRITE unconditionally.
REQ-020 WRITE SHALL set record[{cap_user, cap_song}] = cap_score only if cap_score > the stored value (unsigned compare).
- On a write, new_best SHALL pulse for exactly that cycle.
- The FSM SHALL then go to SUM.
REQ-021 On a clear edge, the FSM SHALL go to CLEAR, latch cap_user = user, zero all four records of cap_user in one cycle, then go to SUM.
REQ-022 On a user change with no other request, the FSM SHALL latch cap_user = user and go to SUM.
REQ-023 SUM SHALL take exactly 4 cycles, adding record[{cap_user, k}] for k = 0,1,2,3 into an accumulator of SCORE_W+2 bits that is cleared on SUM entry.
REQ-024 DONE SHALL load user_avg = accumulator >> 2 (truncating), then go to IDLE.
- avg_valid SHALL be set only if cap_user == user; otherwise it stays 0 and the IDLE user-change path recomputes.
REQ-025 avg_valid SHALL drop to 0 on the cycle any FSM transition out of IDLE is taken.
REQ-026 Latency: with the finished edge sampled at clock edge 0, the record write SHALL occur at edge 2, user_avg/avg_valid SHALL update at edge 7, and busy SHALL be high after edges 0 through 6.
REQ-027 A finished or clear edge arriving while busy SHALL set a one-deep pending flag for that request type, serviced on the next IDLE cycle.
- A second edge of the same type while pending SHALL be dropped.
- For a pending finished request, score, user and song_num SHALL be sampled at the edge, not at service time.
REQ-028 A finished edge and a clear edge in the same cycle SHALL service the finished edge first and set the clear request pending.
REQ-029 rec_score SHALL equal record[{user, song_num}] one cycle after any change of user, song_num or that record.
REQ-030 The score compare SHALL be strict: an equal score SHALL NOT write and SHALL NOT pulse new_best.

Reset
REQ-031 While rst_n=0, the block SHALL force all 16 records = 0, user_avg = 0, rec_score = 0, avg_valid = 1, new_best = 0, busy = 0, state = IDLE, pending flags = 0, and fin_q = clr_q = 0.
- user_q SHALL reset to the current user input so that no recompute is triggered.
REQ-032 Reset asserted mid-operation SHALL abort immediately; a write not yet performed SHALL be lost.

Verification
REQ-033 Basic capture: after reset, user=1, song=2, score=400, finished rises -> record[6]=400 at edge 2, new_best pulses once, user_avg=100 and avg_valid=1 at edge 7.
REQ-034 No-improve: repeat with score=300, then score=400 -> no write, no new_best, user_avg stays 100.
REQ-035 Truncation: user=1 records 1,1,1,0 -> user_avg=0; records 3,3,3,4 -> user_avg=3.
REQ-036 Pending: clear_user rises 2 cycles after finished while busy -> finished path completes first, then user 1 is cleared, final user_avg=0, busy continuous until done.
REQ-037 User switch: user changes 1->2 during SUM -> avg_valid stays 0 after DONE, recompute for user 2 follows, avg_valid=1 with user 2 average.
REQ-038 Reset mid-WRITE: rst_n low at edge 1 of a capture -> record stays 0, busy=0, avg_valid=1, user_avg=0.
